// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: state encoding and
// wait-counter sizing helper.
package instr_sequencer_pkg;

  typedef logic [2:0] SeqState_t;

  localparam SeqState_t S_IDLE    = 3'd0;
  localparam SeqState_t S_FETCH   = 3'd1;
  localparam SeqState_t S_DECODE  = 3'd2;
  localparam SeqState_t S_MEM     = 3'd3;
  localparam SeqState_t S_LOAD_WB = 3'd4;
  localparam SeqState_t S_HALT    = 3'd5;

  // Wide enough to hold the value `timeout` itself; never zero bits.
  function automatic int timeout_cnt_width(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/mem_timeout_counter.sv
// Saturating wait counter for memory requests; flags when a request has
// waited MEM_TIMEOUT cycles without mem_ready.
module mem_timeout_counter
  import instr_sequencer_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic clk,
  input  logic clear,
  input  logic count,
  output logic expired
);

  localparam int              W     = timeout_cnt_width(MEM_TIMEOUT);
  localparam logic [W-1:0]    LIMIT = W'(MEM_TIMEOUT);

  logic [W-1:0] cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values of its inputs.
  always_ff @(posedge clk) begin
    if (clear) begin
      cnt_q <= '0;
    end else if (count && (cnt_q != LIMIT)) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  // Fires in the cycle whose unanswered wait brings the count to LIMIT,
  // so a mem_ready in that same cycle (count=0) always wins.
  assign expired = (MEM_TIMEOUT != 0) && count && (cnt_q == LIMIT - W'(1));

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: fetch, decode, optional data access and
// load write-back, with a memory wait timeout that halts on a bus error.
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic mem_ready,
  input  logic IsLoad,
  input  logic IsStore,
  input  logic RegWriteDec,
  input  logic IllegalInstr,
  output logic mem_valid,
  output logic mem_instr,
  output logic AddrSrc,
  output logic IRWrite,
  output logic LoadDataWrite,
  output logic MemWrite,
  output logic RegWrite,
  output logic PCUpdate,
  output logic ICycleInc,
  output logic halted,
  output logic bus_error
);

  SeqState_t state_q, state_d;
  logic      reset_q;
  logic      is_load_q, is_store_q;
  logic      load_access;
  logic      timeout_clear, timeout_count, timeout_expired;

  // A store flag wins if the decoder ever asserts both.
  assign load_access = is_load_q && !is_store_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      // Hold IDLE for one full cycle after reset is released.
      S_IDLE:    if (!reset_q) state_d = S_FETCH;
      S_FETCH: begin
        if (mem_ready)            state_d = S_DECODE;
        else if (timeout_expired) state_d = S_HALT;
      end
      S_DECODE: begin
        if (IllegalInstr)            state_d = S_HALT;
        else if (IsLoad || IsStore)  state_d = S_MEM;
        else                         state_d = S_FETCH;
      end
      S_MEM: begin
        if (mem_ready)            state_d = load_access ? S_LOAD_WB : S_FETCH;
        else if (timeout_expired) state_d = S_HALT;
      end
      S_LOAD_WB: state_d = S_FETCH;
      S_HALT:    state_d = S_HALT;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    // NOTE: every output gets a default before the case so no path through
    // this block can leave one unassigned and infer a latch.
    mem_valid     = 1'b0;
    mem_instr     = 1'b0;
    AddrSrc       = 1'b0;
    IRWrite       = 1'b0;
    LoadDataWrite = 1'b0;
    MemWrite      = 1'b0;
    RegWrite      = 1'b0;
    PCUpdate      = 1'b0;
    ICycleInc     = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_valid = 1'b1;
        mem_instr = 1'b1;
        IRWrite   = mem_ready;
      end
      S_DECODE: begin
        if (!IllegalInstr && !IsLoad && !IsStore) begin
          RegWrite  = RegWriteDec;
          PCUpdate  = 1'b1;
          ICycleInc = 1'b1;
        end
      end
      S_MEM: begin
        mem_valid = 1'b1;
        AddrSrc   = 1'b1;
        MemWrite  = is_store_q;
        if (mem_ready) begin
          if (load_access) begin
            LoadDataWrite = 1'b1;
          end else begin
            PCUpdate  = 1'b1;
            ICycleInc = 1'b1;
          end
        end
      end
      S_LOAD_WB: begin
        RegWrite  = 1'b1;
        PCUpdate  = 1'b1;
        ICycleInc = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    reset_q <= reset;
    if (reset) begin
      state_q    <= S_IDLE;
      is_load_q  <= 1'b0;
      is_store_q <= 1'b0;
      halted     <= 1'b0;
      bus_error  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) begin
        is_load_q  <= IsLoad;
        is_store_q <= IsStore;
      end
      halted <= (state_d == S_HALT);
      if (timeout_expired) bus_error <= 1'b1;
    end
  end

  // Restart the wait count for every new request and whenever one completes.
  assign timeout_clear = reset || mem_ready ||
                         ((state_d != state_q) && ((state_d == S_FETCH) || (state_d == S_MEM)));
  assign timeout_count = mem_valid && !mem_ready;

  mem_timeout_counter #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .clear   (timeout_clear),
    .count   (timeout_count),
    .expired (timeout_expired)
  );

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed, table-driven bench for instr_sequencer: one vector per cycle with
// hand-computed outputs, plus a memory-timeout sequence.
module tb_instr_sequencer;

  localparam int TIMEOUT = 4;

  // Input bits of a vector: {reset, mem_ready, IsLoad, IsStore, RegWriteDec, IllegalInstr}
  localparam logic [5:0] RST = 6'b100000;
  localparam logic [5:0] RDY = 6'b010000;
  localparam logic [5:0] LD  = 6'b001000;
  localparam logic [5:0] ST  = 6'b000100;
  localparam logic [5:0] RWD = 6'b000010;
  localparam logic [5:0] ILL = 6'b000001;
  localparam logic [5:0] NOIN = 6'b000000;

  // Output bits: {mem_valid, mem_instr, AddrSrc, IRWrite, LoadDataWrite,
  //               MemWrite, RegWrite, PCUpdate, ICycleInc, halted, bus_error}
  localparam logic [10:0] O_V    = 11'h400;
  localparam logic [10:0] O_I    = 11'h200;
  localparam logic [10:0] O_A    = 11'h100;
  localparam logic [10:0] O_IRW  = 11'h080;
  localparam logic [10:0] O_LDW  = 11'h040;
  localparam logic [10:0] O_MW   = 11'h020;
  localparam logic [10:0] O_RW   = 11'h010;
  localparam logic [10:0] O_PC   = 11'h008;
  localparam logic [10:0] O_IC   = 11'h004;
  localparam logic [10:0] O_H    = 11'h002;
  localparam logic [10:0] O_BE   = 11'h001;
  localparam logic [10:0] O_NONE = 11'h000;

  typedef struct {
    string       name;
    logic [5:0]  in;
    logic [10:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset, mem_ready, IsLoad, IsStore, RegWriteDec, IllegalInstr;
  logic mem_valid, mem_instr, AddrSrc, IRWrite, LoadDataWrite, MemWrite;
  logic RegWrite, PCUpdate, ICycleInc, halted, bus_error;
  logic [10:0] outs;

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  instr_sequencer #(.MEM_TIMEOUT(TIMEOUT)) dut (
    .clk           (clk),
    .reset         (reset),
    .mem_ready     (mem_ready),
    .IsLoad        (IsLoad),
    .IsStore       (IsStore),
    .RegWriteDec   (RegWriteDec),
    .IllegalInstr  (IllegalInstr),
    .mem_valid     (mem_valid),
    .mem_instr     (mem_instr),
    .AddrSrc       (AddrSrc),
    .IRWrite       (IRWrite),
    .LoadDataWrite (LoadDataWrite),
    .MemWrite      (MemWrite),
    .RegWrite      (RegWrite),
    .PCUpdate      (PCUpdate),
    .ICycleInc     (ICycleInc),
    .halted        (halted),
    .bus_error     (bus_error)
  );

  assign outs = {mem_valid, mem_instr, AddrSrc, IRWrite, LoadDataWrite,
                 MemWrite, RegWrite, PCUpdate, ICycleInc, halted, bus_error};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input logic [5:0] in, input logic [10:0] exp);
    vec_t v;
    v.name = name;
    v.in   = in;
    v.exp  = exp;
    return v;
  endfunction

  // Drive one cycle's inputs on the falling edge and check the outputs
  // before the next rising edge.
  task automatic apply(input vec_t v);
    @(negedge clk);
    {reset, mem_ready, IsLoad, IsStore, RegWriteDec, IllegalInstr} = v.in;
    #1;
    check(v.name, 32'(outs), 32'(v.exp));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int  waits;
    bit  done;

    reset = 1'b1;
    {mem_ready, IsLoad, IsStore, RegWriteDec, IllegalInstr} = '0;

    // Reset and release: two IDLE cycles, then fetch.
    vecs.push_back(mk("reset_idle",      RST,          O_NONE));
    vecs.push_back(mk("release_idle0",   NOIN,         O_NONE));
    vecs.push_back(mk("release_idle1",   NOIN,         O_NONE));
    // ALU instruction with zero-wait memory, RegWriteDec=1 then 0.
    vecs.push_back(mk("alu1_fetch",      RDY,          O_V | O_I | O_IRW));
    vecs.push_back(mk("alu1_commit",     RDY | RWD,    O_RW | O_PC | O_IC));
    vecs.push_back(mk("alu2_fetch",      RDY,          O_V | O_I | O_IRW));
    vecs.push_back(mk("alu2_commit",     RDY,          O_PC | O_IC));
    // Load with three wait cycles in MEM; stray mem_ready ignored outside requests.
    vecs.push_back(mk("ld_fetch",        RDY,          O_V | O_I | O_IRW));
    vecs.push_back(mk("ld_decode",       RDY | LD,     O_NONE));
    vecs.push_back(mk("ld_mem_wait1",    NOIN,         O_V | O_A));
    vecs.push_back(mk("ld_mem_wait2",    NOIN,         O_V | O_A));
    vecs.push_back(mk("ld_mem_wait3",    NOIN,         O_V | O_A));
    vecs.push_back(mk("ld_mem_ready",    RDY,          O_V | O_A | O_LDW));
    vecs.push_back(mk("ld_writeback",    RDY,          O_RW | O_PC | O_IC));
    // Store with one fetch wait and one MEM wait.
    vecs.push_back(mk("st_fetch_wait",   NOIN,         O_V | O_I));
    vecs.push_back(mk("st_fetch",        RDY,          O_V | O_I | O_IRW));
    vecs.push_back(mk("st_decode",       ST | RWD,     O_NONE));
    vecs.push_back(mk("st_mem_wait",     NOIN,         O_V | O_A | O_MW));
    vecs.push_back(mk("st_commit",       RDY | RWD,    O_V | O_A | O_MW | O_PC | O_IC));
    // Illegal instruction beats IsLoad, halts until reset.
    vecs.push_back(mk("ill_fetch",       RDY,          O_V | O_I | O_IRW));
    vecs.push_back(mk("ill_decode",      ILL | LD | RWD, O_NONE));
    vecs.push_back(mk("ill_halted0",     RDY,          O_H));
    vecs.push_back(mk("ill_halted1",     RDY,          O_H));
    vecs.push_back(mk("ill_reset",       RST,          O_H));
    vecs.push_back(mk("ill_idle0",       NOIN,         O_NONE));
    vecs.push_back(mk("ill_idle1",       NOIN,         O_NONE));
    // Reset during an outstanding store.
    vecs.push_back(mk("rst_st_fetch",    RDY,          O_V | O_I | O_IRW));
    vecs.push_back(mk("rst_st_decode",   ST,           O_NONE));
    vecs.push_back(mk("rst_st_mem",      RST,          O_V | O_A | O_MW));
    vecs.push_back(mk("rst_st_dropped",  NOIN,         O_NONE));
    vecs.push_back(mk("rst_st_idle",     NOIN,         O_NONE));
    vecs.push_back(mk("rst_st_refetch",  NOIN,         O_V | O_I));
    // mem_ready in the last allowed wait cycle wins over the timeout.
    vecs.push_back(mk("to_edge_wait2",   NOIN,         O_V | O_I));
    vecs.push_back(mk("to_edge_wait3",   NOIN,         O_V | O_I));
    vecs.push_back(mk("to_edge_ready4",  RDY,          O_V | O_I | O_IRW));
    vecs.push_back(mk("to_edge_commit",  NOIN,         O_PC | O_IC));
    // Fetch timeout after four unanswered cycles.
    vecs.push_back(mk("to_fetch_wait1",  NOIN,         O_V | O_I));
    vecs.push_back(mk("to_fetch_wait2",  NOIN,         O_V | O_I));
    vecs.push_back(mk("to_fetch_wait3",  NOIN,         O_V | O_I));
    vecs.push_back(mk("to_fetch_wait4",  NOIN,         O_V | O_I));
    vecs.push_back(mk("to_fetch_halt",   RDY,          O_H | O_BE));
    vecs.push_back(mk("to_fetch_reset",  RST,          O_H | O_BE));
    vecs.push_back(mk("to_fetch_clear",  NOIN,         O_NONE));

    repeat (2) @(posedge clk);
    foreach (vecs[i]) apply(vecs[i]);

    // Load whose data access never completes: count MEM wait cycles until halt.
    apply(mk("mt_idle",        NOIN, O_NONE));
    apply(mk("mt_fetch",       RDY,  O_V | O_I | O_IRW));
    apply(mk("mt_decode_load", LD,   O_NONE));
    waits = 0;
    done  = 1'b0;
    for (int i = 0; i < 12 && !done; i++) begin
      @(negedge clk);
      {reset, mem_ready, IsLoad, IsStore, RegWriteDec, IllegalInstr} = '0;
      #1;
      if (halted) done = 1'b1;
      else if (mem_valid && AddrSrc) waits++;
    end
    check("mt_halt_reached", 32'(done),      32'd1);
    check("mt_wait_cycles",  32'(waits),     32'(TIMEOUT));
    check("mt_bus_error",    32'(bus_error), 32'd1);
    check("mt_valid_low",    32'(mem_valid), 32'd0);
    apply(mk("mt_reset",       RST,  O_H | O_BE));
    apply(mk("mt_cleared",     NOIN, O_NONE));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
